// File: rtl/ov5640_burst_wr.sv
// Pixel-to-SDRAM burst writer: buffers camera pixels in a FIFO and hands them to the SDRAM
// write port as fixed-length, frame-addressed bursts using a req/ack handshake.
`timescale 1ns/1ps

module ov5640_burst_wr #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter logic [23:0] BASE_ADDR   = 24'd0,
  parameter logic [23:0] FRAME_WORDS = 24'd786432
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ov5640_vsync,
  input  logic        pix_wr_en,
  input  logic [15:0] pix_data,
  output logic        burst_req,
  input  logic        burst_ack,
  output logic [23:0] burst_addr,
  output logic [15:0] wr_data,
  output logic        wr_data_en,
  output logic        frame_done,
  output logic        overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEATS     = BEAT_W'(BURST_LEN);
  localparam logic [23:0]       ADDR_STEP = 24'(BURST_LEN);
  localparam logic [23:0]       FRAME_END = BASE_ADDR + FRAME_WORDS;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              vsync_p0;
  logic              vsync_p1;
  logic              frame_start;
  logic              pending;
  state_t            state;
  logic [BEAT_W-1:0] beat;

  logic              burst_end;
  logic              flush;
  logic              pop;
  logic              push;
  logic              wrap;

  // beat reaches BURST_LEN after the last pop; that extra XFER cycle is where the burst retires
  assign frame_start = vsync_p0 & ~vsync_p1;
  assign burst_end   = (state == XFER) && (beat == BEATS);
  assign flush       = (frame_start && (state != XFER)) ||
                       (burst_end && (pending || frame_start));
  assign pop         = ((state == REQ) && burst_ack && !frame_start) ||
                       ((state == XFER) && (beat != BEATS));
  assign push        = pix_wr_en && (count != DEPTH_C) && !flush;
  assign wrap        = (burst_addr + ADDR_STEP) == FRAME_END;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
      if (pix_wr_en && (count == DEPTH_C)) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_p0   <= 1'b0;
      vsync_p1   <= 1'b0;
      state      <= IDLE;
      pending    <= 1'b0;
      beat       <= '0;
      burst_req  <= 1'b0;
      burst_addr <= BASE_ADDR;
      wr_data    <= '0;
      wr_data_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync_p0   <= ov5640_vsync;
      vsync_p1   <= vsync_p0;
      frame_done <= 1'b0;
      wr_data_en <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            burst_addr <= BASE_ADDR;
          end else if (count >= BURST_C) begin
            state     <= REQ;
            burst_req <= 1'b1;
          end
        end
        REQ: begin
          if (frame_start) begin
            burst_req  <= 1'b0;
            burst_addr <= BASE_ADDR;
            state      <= IDLE;
          end else if (burst_ack) begin
            // first word leaves on the ack edge so data is valid the cycle after the grant
            burst_req  <= 1'b0;
            state      <= XFER;
            wr_data    <= mem[rd_ptr];
            wr_data_en <= 1'b1;
            beat       <= BEAT_W'(1);
          end
        end
        XFER: begin
          if (beat != BEATS) begin
            wr_data    <= mem[rd_ptr];
            wr_data_en <= 1'b1;
            beat       <= beat + BEAT_W'(1);
            if (frame_start) begin
              pending <= 1'b1;
            end
          end else begin
            state      <= IDLE;
            pending    <= 1'b0;
            beat       <= '0;
            frame_done <= wrap;
            burst_addr <= (wrap || pending || frame_start) ? BASE_ADDR : burst_addr + ADDR_STEP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_burst_wr.sv
// Bench for ov5640_burst_wr: table-driven scenarios, randomized traffic against a queue model,
// and hand-written frame-start / async-reset sequences.
`timescale 1ns/1ps

module tb_ov5640_burst_wr;

  localparam int          BL   = 4;
  localparam int          FD   = 8;
  localparam logic [23:0] BASE = 24'h000010;
  localparam logic [23:0] FW   = 24'd8;
  localparam int          BPF  = int'(FW) / BL;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        pix_wr_en;
  logic [15:0] pix_data;
  logic        burst_req;
  logic        burst_ack;
  logic [23:0] burst_addr;
  logic [15:0] wr_data;
  logic        wr_data_en;
  logic        frame_done;
  logic        overflow;

  ov5640_burst_wr #(
    .BURST_LEN  (BL),
    .FIFO_DEPTH (FD),
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .ov5640_vsync(vsync),
    .pix_wr_en   (pix_wr_en),
    .pix_data    (pix_data),
    .burst_req   (burst_req),
    .burst_ack   (burst_ack),
    .burst_addr  (burst_addr),
    .wr_data     (wr_data),
    .wr_data_en  (wr_data_en),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  typedef struct {
    int          n;
    logic [15:0] first;
    int          gap;
    int          dly;
    int          keep;
    int          bursts;
    int          fds;
    logic        ovf;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] data_q[$];
  logic [23:0] addr_q[$];
  int          fd_cnt = 0;
  int          run = 0;
  bit          prev_en = 0;
  bit          ack_en = 0;
  bit          rnd_ack = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // SDRAM-side responder: grants each request after ack_delay cycles
  initial begin
    burst_ack = 1'b0;
    forever begin
      @(negedge clk);
      burst_ack = 1'b0;
      if (!burst_req || !ack_en) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        burst_ack = 1'b1;
        wait_cnt  = 0;
        if (rnd_ack) ack_delay = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
  end

  // Output monitor: collects bursts, checks burst length and frame_done placement
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run     = 0;
        prev_en = 0;
      end else begin
        if (wr_data_en) begin
          if (!prev_en) addr_q.push_back(burst_addr);
          data_q.push_back(wr_data);
          run++;
        end else if (prev_en) begin
          check("burst_len", run, BL);
          run = 0;
        end
        if (frame_done) begin
          fd_cnt++;
          check("fd_after_last_word", {31'b0, prev_en}, 32'd1);
        end
        prev_en = wr_data_en;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    data_q.delete();
    addr_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    vsync     = 1'b0;
    pix_wr_en = 1'b0;
    pix_data  = '0;
    ack_en    = 1'b0;
    rnd_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", burst_req, 0);
    check("rst_addr", burst_addr, BASE);
    check("rst_en", wr_data_en, 0);
    check("rst_data", wr_data, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    clear_mon();
  endtask

  // gap < 0 picks a random gap of 3..6 idle cycles; only the first 'keep' pixels reach the model
  task automatic push_px(input int n, input logic [15:0] first, input int gap, input int keep,
                         input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_wr_en = 1'b1;
      pix_data  = rnd ? 16'($urandom) : first + 16'(i);
      if (i < keep) exp_q.push_back(pix_data);
      g = (gap < 0) ? int'($urandom_range(3, 6)) : gap;
      repeat (g) begin
        @(negedge clk);
        pix_wr_en = 1'b0;
      end
    end
    @(negedge clk);
    pix_wr_en = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (data_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (data_q.size() < n) check("timeout_words", data_q.size(), n);
    repeat (4) @(negedge clk);
  endtask

  // Expected address of burst k: frame-relative slot, restarting at 'restart' after a frame flush
  task automatic verify(input int nw, input int nb, input int nf, input logic ov, input int restart);
    check("words", data_q.size(), nw);
    for (int j = 0; j < nw && j < data_q.size(); j++)
      check($sformatf("data[%0d]", j), data_q[j], exp_q[j]);
    check("bursts", addr_q.size(), nb);
    for (int k = 0; k < addr_q.size(); k++) begin
      int idx;
      idx = (k >= restart) ? k - restart : k;
      check($sformatf("addr[%0d]", k), addr_q[k], BASE + 24'((idx % BPF) * BL));
    end
    check("frame_done_cnt", fd_cnt, nf);
    check("overflow", overflow, ov);
  endtask

  initial begin
    vec_t vecs[5];
    int   nw;
    int   c;

    rst_n     = 1'b0;
    vsync     = 1'b0;
    pix_wr_en = 1'b0;
    pix_data  = '0;

    vecs = '{
      '{8,  16'h0001, 0, 3,  8,  2, 1, 1'b0},
      '{10, 16'h0001, 0, 20, 8,  2, 1, 1'b1},
      '{12, 16'h1000, 2, 1,  12, 3, 1, 1'b0},
      '{6,  16'hA5A0, 0, 0,  6,  1, 0, 1'b0},
      '{16, 16'h7FF0, 1, 2,  16, 4, 2, 1'b0}
    };

    for (int v = 0; v < 5; v++) begin
      do_reset();
      ack_en    = 1'b1;
      ack_delay = vecs[v].dly;
      push_px(vecs[v].n, vecs[v].first, vecs[v].gap, vecs[v].keep, 1'b0);
      nw = (vecs[v].keep / BL) * BL;
      wait_words(nw, 400);
      verify(nw, vecs[v].bursts, vecs[v].fds, vecs[v].ovf, 1000);
    end

    // randomized pixel gaps, data and grant latency
    do_reset();
    ack_en    = 1'b1;
    rnd_ack   = 1'b1;
    ack_delay = $urandom_range(0, 3);
    push_px(40, 16'h0000, -1, 40, 1'b1);
    wait_words(40, 2000);
    verify(40, 10, 5, 1'b0, 1000);

    // frame start while a request is pending with a full, overflowed FIFO
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 0;
    push_px(4, 16'h0001, 0, 4, 1'b0);
    wait_words(4, 100);
    ack_en = 1'b0;
    push_px(10, 16'h0005, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("req_held", burst_req, 1);
    check("req_addr", burst_addr, BASE + 24'(BL));
    check("ovf_set", overflow, 1);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    check("vs_req_drop", burst_req, 0);
    check("vs_ovf_clr", overflow, 0);
    check("vs_addr", burst_addr, BASE);
    vsync = 1'b0;
    clear_mon();
    ack_en = 1'b1;
    push_px(3, 16'h0100, 0, 3, 1'b0);
    repeat (8) @(negedge clk);
    check("vs_fifo_empty", data_q.size(), 0);
    check("vs_no_req", burst_req, 0);
    push_px(1, 16'h0103, 0, 1, 1'b0);
    wait_words(4, 100);
    verify(4, 1, 0, 1'b0, 1000);

    // frame start in the middle of a burst
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 0;
    push_px(6, 16'h0001, 0, 4, 1'b0);
    c = 0;
    while (!wr_data_en && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("mx_xfer_seen", wr_data_en, 1);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    wait_words(4, 100);
    check("mx_addr_base", burst_addr, BASE);
    push_px(4, 16'h0200, 0, 4, 1'b0);
    wait_words(8, 100);
    verify(8, 2, 0, 1'b0, 1);

    // asynchronous reset in the middle of a burst
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 0;
    push_px(4, 16'h0001, 0, 4, 1'b0);
    wait_words(4, 100);
    push_px(5, 16'h0010, 0, 0, 1'b0);
    c = 0;
    while (!wr_data_en && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("ar_xfer_seen", wr_data_en, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_en", wr_data_en, 0);
    check("ar_req", burst_req, 0);
    check("ar_addr", burst_addr, BASE);
    check("ar_data", wr_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    push_px(4, 16'h0300, 0, 4, 1'b0);
    wait_words(4, 100);
    verify(4, 1, 0, 1'b0, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
